// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the bus memory responder.
// The FSM and op encodings live here so the top and the bench agree on them.
package bus_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  localparam logic [31:0] BAD_READ    = 32'hBAD1BAD1;
  localparam int unsigned XFER_CNT_W  = 16;
  localparam int unsigned ABORT_CNT_W = 8;
  localparam int unsigned LAT_CNT_W   = 4;

  // A write strobe dominates a simultaneous read strobe.
  function automatic op_e decode_op(input logic ren, input logic wen);
    if (wen) begin
      return OP_WRITE;
    end else if (ren) begin
      return OP_READ;
    end
    return OP_NONE;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port word store: synchronous write, asynchronous read.
// Holds no reset so contents survive a responder reset.
module word_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Bus-side memory responder: holds dwait high for LAT cycles, then completes
// one read or write from word_ram, restarting if the request changes mid-flight.
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   dREN,
  input  logic                   dWEN,
  input  logic [31:0]            daddr,
  input  logic [31:0]            dstore,
  output logic [31:0]            dload,
  output logic                   dwait,
  output logic [XFER_CNT_W-1:0]  rd_count,
  output logic [XFER_CNT_W-1:0]  wr_count,
  output logic [ABORT_CNT_W-1:0] abort_count
);

  localparam int unsigned         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LAT_CNT_W-1:0] CNT_INIT  = LAT_CNT_W'(LAT - 1);
  localparam state_e              RESTART_ST = (LAT == 1) ? ACCESS : WAIT;

  state_e                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  op_e                    op_q, op_d;
  logic [29:0]            idx_q, idx_d;
  logic [31:0]            data_q, data_d;
  logic [XFER_CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [XFER_CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [ABORT_CNT_W-1:0] abort_count_q, abort_count_d;

  op_e         req_op;
  logic        req_same;
  logic        in_range;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        rd_inc, wr_inc, abort_inc;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^daddr[1:0];

  assign req_op   = decode_op(dREN, dWEN);
  assign req_same = (req_op == op_q) && (daddr[31:2] == idx_q);
  assign in_range = ({2'b00, idx_q} < DEPTH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    idx_d     = idx_q;
    data_d    = data_q;
    rd_inc    = 1'b0;
    wr_inc    = 1'b0;
    abort_inc = 1'b0;
    ram_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_op != OP_NONE) begin
          op_d    = req_op;
          idx_d   = daddr[31:2];
          data_d  = dstore;
          cnt_d   = CNT_INIT;
          state_d = RESTART_ST;
        end
      end

      WAIT: begin
        if (req_op == OP_NONE) begin
          state_d   = IDLE;
          abort_inc = 1'b1;
        end else if (!req_same) begin
          op_d      = req_op;
          idx_d     = daddr[31:2];
          data_d    = dstore;
          cnt_d     = CNT_INIT;
          state_d   = RESTART_ST;
          abort_inc = 1'b1;
        end else begin
          // Same target: track the newest write data without restarting.
          data_d = dstore;
          if (cnt_q <= LAT_CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            cnt_d = cnt_q - LAT_CNT_W'(1);
          end
        end
      end

      ACCESS: begin
        if (req_op == OP_NONE) begin
          state_d   = IDLE;
          abort_inc = 1'b1;
        end else if (!req_same) begin
          op_d      = req_op;
          idx_d     = daddr[31:2];
          data_d    = dstore;
          cnt_d     = CNT_INIT;
          state_d   = RESTART_ST;
          abort_inc = 1'b1;
        end else begin
          state_d = IDLE;
          if (op_q == OP_WRITE) begin
            wr_inc = 1'b1;
            ram_we = in_range;
          end else begin
            rd_inc = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Counters stick at all-ones instead of wrapping.
    rd_count_d    = (rd_inc && (rd_count_q != '1)) ? rd_count_q + 1'b1 : rd_count_q;
    wr_count_d    = (wr_inc && (wr_count_q != '1)) ? wr_count_q + 1'b1 : wr_count_q;
    abort_count_d = (abort_inc && (abort_count_q != '1)) ? abort_count_q + 1'b1
                                                         : abort_count_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= OP_NONE;
      idx_q         <= '0;
      data_q        <= '0;
      rd_count_q    <= '0;
      wr_count_q    <= '0;
      abort_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      rd_count_q    <= rd_count_d;
      wr_count_q    <= wr_count_d;
      abort_count_q <= abort_count_d;
    end
  end

  word_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_word_ram (
    .clk  (CLK),
    .we   (ram_we),
    .addr (idx_q[AW-1:0]),
    .wdata(data_q),
    .rdata(ram_rdata)
  );

  assign dwait       = (state_q != ACCESS);
  assign dload       = ((state_q == ACCESS) && (op_q == OP_READ))
                       ? (in_range ? ram_rdata : BAD_READ) : 32'h0;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign abort_count = abort_count_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: one LAT=2 and one LAT=3 instance,
// expected latency/data queued at request time and checked at completion.
module tb_bus_mem_responder;
  import bus_mem_pkg::*;

  localparam int LAT0   = 2;
  localparam int LAT1   = 3;
  localparam int DEPTH0 = 1024;
  localparam int DEPTH1 = 16;
  localparam int BUDGET = 40;

  typedef struct {
    string       tag;
    int          lat;
    logic [31:0] data;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic        ren     [2];
  logic        wen     [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [31:0] dload_w [2];
  logic        dwait_w [2];
  logic [15:0] rdc     [2];
  logic [15:0] wrc     [2];
  logic [7:0]  abc     [2];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_rd [2];
  int exp_wr [2];
  int exp_ab [2];

  sb_item_t    sb [$];
  logic [31:0] model_mem [longint];

  always #5 clk = ~clk;

  bus_mem_responder #(.LAT(LAT0), .DEPTH(DEPTH0)) u_dut0 (
    .CLK(clk), .RST(rst[0]), .dREN(ren[0]), .dWEN(wen[0]),
    .daddr(addr[0]), .dstore(wdata[0]), .dload(dload_w[0]), .dwait(dwait_w[0]),
    .rd_count(rdc[0]), .wr_count(wrc[0]), .abort_count(abc[0])
  );

  bus_mem_responder #(.LAT(LAT1), .DEPTH(DEPTH1)) u_dut1 (
    .CLK(clk), .RST(rst[1]), .dREN(ren[1]), .dWEN(wen[1]),
    .daddr(addr[1]), .dstore(wdata[1]), .dload(dload_w[1]), .dwait(dwait_w[1]),
    .rd_count(rdc[1]), .wr_count(wrc[1]), .abort_count(abc[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_counters(input int s, input string tag);
    check_val({tag, "_rd_count"}, 32'(rdc[s]), 32'(exp_rd[s]));
    check_val({tag, "_wr_count"}, 32'(wrc[s]), 32'(exp_wr[s]));
    check_val({tag, "_abort_count"}, 32'(abc[s]), 32'(exp_ab[s]));
  endtask

  // One bus transaction; optionally changes address/data at cycle t+chg.
  task automatic txn(input int s, input string tag, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input int chg, input logic [31:0] a2, input logic [31:0] d2);
    sb_item_t    it;
    sb_item_t    got_it;
    logic [31:0] fa, fd;
    longint      key;
    int          lat_s, dep_s, got, k;
    bit          done, restarted;

    lat_s     = (s == 0) ? LAT0 : LAT1;
    dep_s     = (s == 0) ? DEPTH0 : DEPTH1;
    fa        = (chg > 0) ? a2 : a;
    fd        = (chg > 0) ? d2 : d;
    restarted = (chg > 0) && (a2[31:2] != a[31:2]);
    key       = (longint'(s) << 32) | longint'(fa[31:2]);

    it.tag = tag;
    it.lat = lat_s + (restarted ? chg : 0);
    if (wr)
      it.data = 32'h0;
    else if (int'(fa[31:2]) >= dep_s)
      it.data = BAD_READ;
    else
      it.data = model_mem.exists(key) ? model_mem[key] : 32'h0;
    sb.push_back(it);

    @(posedge clk); #1;
    ren[s] = rd; wen[s] = wr; addr[s] = a; wdata[s] = d;

    got = -1; k = 0; done = 1'b0;
    while (!done && k <= BUDGET) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == chg) begin
          addr[s] = a2; wdata[s] = d2;
        end
      end
      @(negedge clk);
      if (dwait_w[s] === 1'b0) begin
        got = k; done = 1'b1;
      end else begin
        check_val({tag, "_dload_while_wait"}, dload_w[s], 32'h0);
        k++;
      end
    end

    got_it = sb.pop_front();
    check_val({got_it.tag, "_latency"}, 32'(got), 32'(got_it.lat));
    if (got >= 0)
      check_val({got_it.tag, "_dload"}, dload_w[s], got_it.data);

    if (wr) begin
      exp_wr[s]++;
      if (int'(fa[31:2]) < dep_s) model_mem[key] = fd;
    end else begin
      exp_rd[s]++;
    end
    if (restarted) exp_ab[s]++;

    @(posedge clk); #1;
    ren[s] = 1'b0; wen[s] = 1'b0;
    @(negedge clk);
    check_val({tag, "_dwait_after"}, 32'(dwait_w[s]), 32'h1);
    check_val({tag, "_dload_after"}, dload_w[s], 32'h0);
    $display("[TB] txn dut%0d %s addr=%h latency=%0d dload=%h", s, tag, fa, got, dload_w[s]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; ren[s] = 1'b0; wen[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
      exp_rd[s] = 0; exp_wr[s] = 0; exp_ab[s] = 0;
    end

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_val("reset_dwait", 32'(dwait_w[s]), 32'h1);
      check_val("reset_dload", dload_w[s], 32'h0);
      check_counters(s, "reset");
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // LAT=2 instance: basic write/read, write-wins, data relatch, out-of-range.
    txn(0, "wr40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    check_counters(0, "after_wr40");
    txn(0, "rd40", 1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h0, 32'h0);
    check_counters(0, "after_rd40");
    txn(0, "both10", 1'b1, 1'b1, 32'h10, 32'h12345678, 0, 32'h0, 32'h0);
    txn(0, "rd10", 1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h0, 32'h0);
    txn(0, "wr44_relatch", 1'b0, 1'b1, 32'h44, 32'hAAAA0044, 1, 32'h44, 32'hBBBB0044);
    txn(0, "rd44", 1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h0, 32'h0);
    txn(0, "wr0", 1'b0, 1'b1, 32'h0, 32'h00C0FFEE, 0, 32'h0, 32'h0);
    txn(0, "wr_oob", 1'b0, 1'b1, 32'(4 * DEPTH0), 32'h99999999, 0, 32'h0, 32'h0);
    txn(0, "rd_oob", 1'b1, 1'b0, 32'(4 * DEPTH0), 32'h0, 0, 32'h0, 32'h0);
    txn(0, "rd0", 1'b1, 1'b0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    check_counters(0, "after_oob");

    // Reset in the middle of a write must leave memory untouched.
    txn(0, "wr20", 1'b0, 1'b1, 32'h20, 32'h11112020, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    wen[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h55;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    exp_rd[0] = 0; exp_wr[0] = 0; exp_ab[0] = 0;
    @(negedge clk);
    check_val("midreset_dwait", 32'(dwait_w[0]), 32'h1);
    check_val("midreset_dload", dload_w[0], 32'h0);
    check_counters(0, "midreset");
    @(posedge clk); #1;
    rst[0] = 1'b0; wen[0] = 1'b0;
    txn(0, "rd20_after_reset", 1'b1, 1'b0, 32'h20, 32'h0, 0, 32'h0, 32'h0);
    check_counters(0, "final0");

    // LAT=3 instance: address change restarts, dropped request aborts.
    txn(1, "wr84", 1'b0, 1'b1, 32'h84, 32'hA5A50084, 0, 32'h0, 32'h0);
    txn(1, "wr80", 1'b0, 1'b1, 32'h80, 32'h80808080, 0, 32'h0, 32'h0);
    txn(1, "rd80_to_84", 1'b1, 1'b0, 32'h80, 32'h0, 1, 32'h84, 32'h0);
    check_counters(1, "after_restart");
    @(posedge clk); #1;
    ren[1] = 1'b1; addr[1] = 32'h8;
    @(posedge clk); #1;
    ren[1] = 1'b0;
    exp_ab[1]++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("drop_dwait", 32'(dwait_w[1]), 32'h1);
    end
    $display("[TB] txn dut1 drop addr=00000008 aborted");
    check_counters(1, "final1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
